// File: rtl/rf_param.sv
// +----------------------------------------------------------------------------+
// | Module  : rf_param                                                         |
// | Brief   : Multi-read-port register file with r0 hardwired to zero, per-    |
// |           port read hold registers and a per-register busy scoreboard.     |
// |           Optional macro RF_BYPASS_EN enables write-through forwarding.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rf_param #(
  parameter int DATA_W = 17,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  input  logic [NUM_RD-1:0]          rd_en,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       alloc_en,
  input  logic [ADDR_W-1:0]          alloc_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              w_wr_ok;
  logic              w_alloc_ok;

  assign w_wr_ok    = wr_en && (wr_addr != '0);
  assign w_alloc_ok = alloc_en && (alloc_addr != '0);

  // Entry 0 is reset and never written, so it always reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (w_wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Alloc is applied after the write clear so it wins on an address collision.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (w_alloc_ok) begin
      busy_d[alloc_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_fwd;
    logic              w_busy_clr;
    logic [DATA_W-1:0] w_live;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] hold_d;

    assign w_addr = rd_addr[i*ADDR_W +: ADDR_W];

`ifdef RF_BYPASS_EN
    assign w_fwd      = w_wr_ok && (wr_addr == w_addr);
    assign w_busy_clr = w_fwd && !(w_alloc_ok && (alloc_addr == w_addr));
`else
    assign w_fwd      = 1'b0;
    assign w_busy_clr = 1'b0;
`endif

    assign w_live = w_fwd ? wr_data : mem_q[w_addr];
    assign w_data = rd_en[i] ? w_live : hold_q;
    assign hold_d = rd_en[i] ? w_live : hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q <= '0;
      end else begin
        hold_q <= hold_d;
      end
    end

    // Outputs are forced low during reset so a forwarded wr_data cannot leak out.
    assign rd_data[i*DATA_W +: DATA_W] = rst_n ? w_data : '0;
    assign rd_busy[i] = rst_n && busy_q[w_addr] && !w_busy_clr;
  end

endmodule

`default_nettype wire

// File: doc/rf_param.md
RF_PARAM -- requirements
Module: rf_param

Interface
REQ-001 Parameter DATA_W, default 17, data word width in bits.
REQ-002 Parameter ADDR_W, default 4, register address width; depth = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-007 rd_en  input  NUM_RD  per-port read enable.
REQ-008 rd_data  output  NUM_RD*DATA_W  packed read data; port i at bits [i*DATA_W +: DATA_W].
REQ-009 rd_busy  output  NUM_RD  per-port scoreboard busy flag of the addressed register.
REQ-010 wr_en  input  1  write enable.
REQ-011 wr_addr  input  ADDR_W  write address.
REQ-012 wr_data  input  DATA_W  write data.
REQ-013 alloc_en  input  1  mark a register as pending a future write.
REQ-014 alloc_addr  input  ADDR_W  register to mark busy.

Function
REQ-015 Storage: 2**ADDR_W flop words; write occurs on the rising clk edge when wr_en=1 and wr_addr!=0.
REQ-016 Register 0 shall be hardwired zero: writes ignored, reads return 0, busy flag always 0.
REQ-017 Read with rd_en[i]=1: rd_data port i is combinational from rd_addr[i], zero latency.
REQ-018 Read with rd_en[i]=0: rd_data port i holds the value presented on the last edge at which rd_en[i] was 1 (per-port hold register).
REQ-019 Hold register for port i captures the presented rd_data value on each rising edge with rd_en[i]=1.
REQ-020 Scoreboard: one busy bit per register; alloc_en=1 with alloc_addr!=0 sets busy[alloc_addr] at the edge.
REQ-021 A write with wr_en=1 clears busy[wr_addr] at the edge.
REQ-022 Simultaneous alloc and write to the same address: alloc wins, busy stays/becomes 1, data is still written.
REQ-023 rd_busy[i] = busy[rd_addr[i]] combinationally, independent of rd_en; when RF_BYPASS_EN is defined and a same-cycle write targets rd_addr[i] (nonzero), rd_busy[i]=0 unless a same-cycle alloc also targets that address.
REQ-024 Multiple read ports addressing the same register shall return identical data.
REQ-025 No arbitration among read ports; all ports are served every cycle.

Reset
REQ-026 rst_n=0 shall immediately clear all storage words, all busy bits and all hold registers to 0, regardless of clk.
REQ-027 While rst_n=0: rd_data=0 on all ports, rd_busy=0; writes and allocs are ignored.
REQ-028 Reset asserted mid-operation discards any write or alloc in that cycle; first write is accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro RF_BYPASS_EN defined: a read with rd_en[i]=1 and rd_addr[i]==wr_addr!=0 while wr_en=1 returns wr_data in the same cycle (write-through forwarding).
REQ-030 RF_BYPASS_EN undefined: such a read returns the pre-write stored value; new data is visible from the next cycle; rd_busy follows stored busy bits only.

Verification
REQ-031 Reset then read all addresses on both ports -> every rd_data=0, rd_busy=0.
REQ-032 Write 17'h1ABCD to r5, next cycle read r5 on port 0 and port 1 -> both 17'h1ABCD.
REQ-033 Write 17'h0FFFF to r0, read r0 -> 0; alloc r0 -> rd_busy=0.
REQ-034 Same cycle write 17'h00123 to r7 and read r7: with RF_BYPASS_EN -> 17'h00123; without -> old value, 17'h00123 next cycle.
REQ-035 Alloc r3 -> rd_busy=1 next cycle; write r3 with simultaneous alloc r3 -> busy stays 1; plain write r3 -> busy 0.
REQ-036 Read r5 with rd_en=1, deassert rd_en, write 17'h00042 to r5 -> rd_data holds prior r5 value; assert rst_n=0 mid-cycle -> rd_data=0 immediately.
